// File: rtl/memory_sequencer.sv
// memory_sequencer
//   Sequences a multi-record block memory through initialisation, record load,
//   hash write-back and data write-back. A record pointer advances through the
//   memory after every completed data write-back and wraps at the top.
//
// Ports
//   clock             in   sole clock, rising edge
//   resetn            in   asynchronous active-low reset
//   init_memory       in   request full-memory initialisation (wins over load)
//   load_memory       in   request load of the record at the record pointer
//   process           in   main-controller phase: 3'b010 mining, 3'b100 store
//   done_mining       in   miner finished, mining_hash valid
//   starting_memory   in   word written to every address during initialisation
//   mining_hash       in   new hash, zero-extended onto data_in
//   datapath_out      in   record written back during the data phase
//   write_enable      out  memory write strobe
//   access_type       out  0 = record port, 1 = hash port
//   address           out  memory address
//   data_in           out  memory write data
//   load_registers    out  datapath latches memory read data
//   done_hash_store   out  hash stored, waiting for the store phase
//   done_memory_store out  idle, previous store complete
//   finished_init     out  initialisation complete
//   busy              out  high in every state except idle
module memory_sequencer #(
    parameter int unsigned DATA_W      = 48,
    parameter int unsigned HASH_W      = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned ACCESS_WAIT = 7,
    parameter int unsigned INIT_HOLD   = 7
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              init_memory,
    input  logic              load_memory,
    input  logic [2:0]        process,
    input  logic              done_mining,
    input  logic [DATA_W-1:0] starting_memory,
    input  logic [HASH_W-1:0] mining_hash,
    input  logic [DATA_W-1:0] datapath_out,
    output logic              write_enable,
    output logic              access_type,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              load_registers,
    output logic              done_hash_store,
    output logic              done_memory_store,
    output logic              finished_init,
    output logic              busy
);

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StInit      = 4'd1;
    localparam logic [3:0] StInitHold  = 4'd2;
    localparam logic [3:0] StLoad      = 4'd3;
    localparam logic [3:0] StLatch     = 4'd4;
    localparam logic [3:0] StWaitMine  = 4'd5;
    localparam logic [3:0] StGetPrev   = 4'd6;
    localparam logic [3:0] StWriteHash = 4'd7;
    localparam logic [3:0] StWaitStore = 4'd8;
    localparam logic [3:0] StWriteData = 4'd9;

    localparam int unsigned MaxWait = (ACCESS_WAIT > INIT_HOLD) ? ACCESS_WAIT : INIT_HOLD;
    localparam int unsigned CntW    = (MaxWait > 1) ? $clog2(MaxWait) : 1;

    localparam logic [CntW-1:0] AccLast  = CntW'(ACCESS_WAIT - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(INIT_HOLD - 1);

    logic [3:0]        state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [ADDR_W-1:0] rec_ptr_q, rec_ptr_d;
    logic              timed;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            init_addr_q <= '0;
            rec_ptr_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            init_addr_q <= init_addr_d;
            rec_ptr_q   <= rec_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rec_ptr_d   = rec_ptr_q;
        case (state_q)
            StIdle: begin
                if (init_memory) begin
                    state_d = StInit;
                end else if (load_memory) begin
                    state_d = StLoad;
                end
            end
            StInit: begin
                init_addr_d = init_addr_q + ADDR_W'(1);
                if (init_addr_q == {ADDR_W{1'b1}}) begin
                    state_d     = StInitHold;
                    init_addr_d = '0;
                    rec_ptr_d   = '0;
                end
            end
            StInitHold:  if (wait_cnt_q == HoldLast) state_d = StIdle;
            StLoad:      if (wait_cnt_q == AccLast) state_d = StLatch;
            StLatch:     state_d = StWaitMine;
            StWaitMine:  if (process == 3'b010) state_d = StGetPrev;
            StGetPrev:   if (done_mining) state_d = StWriteHash;
            StWriteHash: if (wait_cnt_q == AccLast) state_d = StWaitStore;
            StWaitStore: if (process == 3'b100) state_d = StWriteData;
            StWriteData: begin
                if (wait_cnt_q == AccLast) begin
                    state_d   = StIdle;
                    rec_ptr_d = rec_ptr_q + ADDR_W'(1);
                end
            end
            default:     state_d = StIdle;
        endcase
    end

    // Counter only runs in timed states; any state change restarts it.
    assign timed = (state_q == StInitHold) || (state_q == StLoad) ||
                   (state_q == StWriteHash) || (state_q == StWriteData);

    always_comb begin
        if (state_d != state_q || !timed) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        write_enable      = 1'b0;
        access_type       = 1'b0;
        address           = rec_ptr_q;
        data_in           = datapath_out;
        load_registers    = 1'b0;
        done_hash_store   = 1'b0;
        done_memory_store = 1'b0;
        finished_init     = 1'b0;
        busy              = (state_q != StIdle);
        case (state_q)
            StIdle:      done_memory_store = 1'b1;
            StInit: begin
                write_enable = 1'b1;
                address      = init_addr_q;
                data_in      = starting_memory;
            end
            StInitHold:  finished_init = 1'b1;
            StLatch:     load_registers = 1'b1;
            StWaitMine:  data_in = DATA_W'(mining_hash);
            StGetPrev: begin
                access_type = 1'b1;
                data_in     = DATA_W'(mining_hash);
            end
            StWriteHash: begin
                write_enable = 1'b1;
                access_type  = 1'b1;
                data_in      = DATA_W'(mining_hash);
            end
            StWaitStore: done_hash_store = 1'b1;
            StWriteData: write_enable = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_memory_sequencer.sv
module tb_memory_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;

    // DUT A: default parameters.
    logic        init_memory, load_memory, done_mining;
    logic [2:0]  process;
    logic [47:0] starting_memory, datapath_out, data_in;
    logic [7:0]  mining_hash;
    logic        write_enable, access_type, load_registers;
    logic        done_hash_store, done_memory_store, finished_init, busy;
    logic [2:0]  address;

    // DUT B: 32-bit records, 16-bit hash, short waits.
    logic        b_init_memory, b_load_memory, b_done_mining;
    logic [2:0]  b_process;
    logic [31:0] b_starting_memory, b_datapath_out, b_data_in;
    logic [15:0] b_mining_hash;
    logic        b_write_enable, b_access_type, b_load_registers;
    logic        b_done_hash_store, b_done_memory_store, b_finished_init, b_busy;
    logic [2:0]  b_address;

    int total = 0;
    int bad   = 0;

    memory_sequencer dut_a (
        .clock(clock), .resetn(resetn),
        .init_memory(init_memory), .load_memory(load_memory), .process(process),
        .done_mining(done_mining), .starting_memory(starting_memory),
        .mining_hash(mining_hash), .datapath_out(datapath_out),
        .write_enable(write_enable), .access_type(access_type), .address(address),
        .data_in(data_in), .load_registers(load_registers),
        .done_hash_store(done_hash_store), .done_memory_store(done_memory_store),
        .finished_init(finished_init), .busy(busy)
    );

    memory_sequencer #(
        .DATA_W(32), .HASH_W(16), .ADDR_W(3), .ACCESS_WAIT(2), .INIT_HOLD(2)
    ) dut_b (
        .clock(clock), .resetn(resetn),
        .init_memory(b_init_memory), .load_memory(b_load_memory), .process(b_process),
        .done_mining(b_done_mining), .starting_memory(b_starting_memory),
        .mining_hash(b_mining_hash), .datapath_out(b_datapath_out),
        .write_enable(b_write_enable), .access_type(b_access_type), .address(b_address),
        .data_in(b_data_in), .load_registers(b_load_registers),
        .done_hash_store(b_done_hash_store), .done_memory_store(b_done_memory_store),
        .finished_init(b_finished_init), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        total++;
        if (done_memory_store !== 1'b1 || busy !== 1'b0 || write_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: dms=%b busy=%b we=%b want 1 0 0",
                     done_memory_store, busy, write_enable);
        end
        total++;
        if (address !== 3'd0 || data_in !== datapath_out) begin
            bad++;
            $display("FAIL reset_bus: addr=%0h data=%0h want 0 %0h", address, data_in,
                     datapath_out);
        end
        total++;
        if ({access_type, load_registers, done_hash_store, finished_init} !== 4'b0) begin
            bad++;
            $display("FAIL reset_misc: got %b want 0000",
                     {access_type, load_registers, done_hash_store, finished_init});
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_init();
        init_memory = 1'b1;
        tick();
        init_memory = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (write_enable !== 1'b1 || address !== 3'(i) || data_in !== starting_memory ||
                busy !== 1'b1) begin
                bad++;
                $display("FAIL init_write[%0d]: we=%b addr=%0d data=%0h busy=%b want 1 %0d %0h 1",
                         i, write_enable, address, data_in, busy, i, starting_memory);
            end
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (finished_init !== 1'b1 || busy !== 1'b1 || write_enable !== 1'b0) begin
                bad++;
                $display("FAIL init_hold[%0d]: fin=%b busy=%b we=%b want 1 1 0",
                         i, finished_init, busy, write_enable);
            end
            tick();
        end
        total++;
        if (finished_init !== 1'b0 || busy !== 1'b0 || done_memory_store !== 1'b1) begin
            bad++;
            $display("FAIL init_end: fin=%b busy=%b dms=%b want 0 0 1",
                     finished_init, busy, done_memory_store);
        end
    endtask

    // One full transaction on DUT A; stop_wd >= 0 returns inside WRITE_DATA.
    task automatic do_txn(input logic [2:0] exp_addr, input int stop_wd);
        logic [2:0] nxt;
        nxt = exp_addr + 3'd1;
        total++;
        if (address !== exp_addr || done_memory_store !== 1'b1) begin
            bad++;
            $display("FAIL txn_idle: addr=%0d dms=%b want %0d 1", address, done_memory_store,
                     exp_addr);
        end
        load_memory = 1'b1;
        tick();
        load_memory = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (load_registers !== 1'b0 || write_enable !== 1'b0 || address !== exp_addr ||
                busy !== 1'b1) begin
                bad++;
                $display("FAIL txn_load[%0d]: lr=%b we=%b addr=%0d busy=%b want 0 0 %0d 1",
                         i, load_registers, write_enable, address, busy, exp_addr);
            end
            tick();
        end
        total++;
        if (load_registers !== 1'b1) begin
            bad++;
            $display("FAIL txn_latch: lr=%b want 1", load_registers);
        end
        tick();
        total++;
        if (load_registers !== 1'b0 || data_in !== 48'h0000_0000_00A5) begin
            bad++;
            $display("FAIL txn_wait_mine: lr=%b data=%0h want 0 a5", load_registers, data_in);
        end
        process = 3'b010;
        tick();
        process = 3'b000;
        tick();
        total++;
        if (access_type !== 1'b1 || write_enable !== 1'b0) begin
            bad++;
            $display("FAIL txn_get_prev: at=%b we=%b want 1 0", access_type, write_enable);
        end
        done_mining = 1'b1;
        tick();
        done_mining = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (write_enable !== 1'b1 || access_type !== 1'b1 ||
                data_in !== 48'h0000_0000_00A5 || address !== exp_addr) begin
                bad++;
                $display("FAIL txn_hash[%0d]: we=%b at=%b data=%0h addr=%0d want 1 1 a5 %0d",
                         i, write_enable, access_type, data_in, address, exp_addr);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done_hash_store !== 1'b1 || write_enable !== 1'b0) begin
                bad++;
                $display("FAIL txn_wait_store[%0d]: dhs=%b we=%b want 1 0",
                         i, done_hash_store, write_enable);
            end
            tick();
        end
        process = 3'b100;
        tick();
        process = 3'b000;
        for (int i = 0; i < 7; i++) begin
            if (i == stop_wd) return;
            total++;
            if (write_enable !== 1'b1 || access_type !== 1'b0 || address !== exp_addr ||
                data_in !== datapath_out || done_hash_store !== 1'b0) begin
                bad++;
                $display("FAIL txn_data[%0d]: we=%b at=%b addr=%0d data=%0h want 1 0 %0d %0h",
                         i, write_enable, access_type, address, data_in, exp_addr,
                         datapath_out);
            end
            tick();
        end
        total++;
        if (done_memory_store !== 1'b1 || write_enable !== 1'b0 || address !== nxt) begin
            bad++;
            $display("FAIL txn_done: dms=%b we=%b addr=%0d want 1 0 %0d",
                     done_memory_store, write_enable, address, nxt);
        end
    endtask

    task automatic test_full_txn();
        do_txn(3'd0, -1);
    endtask

    task automatic test_coincide();
        init_memory = 1'b1;
        load_memory = 1'b1;
        tick();
        init_memory = 1'b0;
        load_memory = 1'b0;
        total++;
        if (write_enable !== 1'b1 || address !== 3'd0 || data_in !== starting_memory) begin
            bad++;
            $display("FAIL coincide_init: we=%b addr=%0d data=%0h want 1 0 %0h",
                     write_enable, address, data_in, starting_memory);
        end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (load_registers !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL coincide_noload[%0d]: lr=%b busy=%b want 0 1",
                         i, load_registers, busy);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0 || address !== 3'd0) begin
            bad++;
            $display("FAIL coincide_end: busy=%b addr=%0d want 0 0", busy, address);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            do_txn(3'(i % 8), -1);
        end
    endtask

    task automatic test_reset_mid_write();
        do_txn(3'd1, 3);
        #3;
        resetn = 1'b0;
        #1;
        total++;
        if (write_enable !== 1'b0 || address !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_now: we=%b addr=%0d busy=%b want 0 0 0",
                     write_enable, address, busy);
        end
        #2;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (write_enable !== 1'b0 || done_memory_store !== 1'b1 || address !== 3'd0) begin
                bad++;
                $display("FAIL midreset_after[%0d]: we=%b dms=%b addr=%0d want 0 1 0",
                         i, write_enable, done_memory_store, address);
            end
        end
    endtask

    task automatic test_stray_b();
        b_load_memory = 1'b1;
        tick();
        b_load_memory = 1'b0;
        tick();
        tick();
        total++;
        if (b_load_registers !== 1'b1) begin
            bad++;
            $display("FAIL b_latch: lr=%b want 1", b_load_registers);
        end
        tick();
        b_done_mining = 1'b1;
        tick();
        b_done_mining = 1'b0;
        total++;
        if (b_access_type !== 1'b0 || b_write_enable !== 1'b0 ||
            b_data_in !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL b_stray_mining: at=%b we=%b data=%0h want 0 0 beef",
                     b_access_type, b_write_enable, b_data_in);
        end
        b_process = 3'b010;
        tick();
        b_process = 3'b000;
        total++;
        if (b_access_type !== 1'b1 || b_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL b_get_prev: at=%b we=%b want 1 0", b_access_type, b_write_enable);
        end
        b_done_mining = 1'b1;
        tick();
        b_done_mining = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (b_write_enable !== 1'b1 || b_access_type !== 1'b1 ||
                b_data_in !== 32'h0000_BEEF) begin
                bad++;
                $display("FAIL b_hash[%0d]: we=%b at=%b data=%0h want 1 1 beef",
                         i, b_write_enable, b_access_type, b_data_in);
            end
            tick();
        end
        b_load_memory = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (b_done_hash_store !== 1'b1 || b_load_registers !== 1'b0) begin
                bad++;
                $display("FAIL b_stray_load[%0d]: dhs=%b lr=%b want 1 0",
                         i, b_done_hash_store, b_load_registers);
            end
            tick();
        end
        b_load_memory = 1'b0;
        b_process = 3'b100;
        tick();
        b_process = 3'b000;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (b_write_enable !== 1'b1 || b_data_in !== b_datapath_out ||
                b_address !== 3'd0) begin
                bad++;
                $display("FAIL b_data[%0d]: we=%b data=%0h addr=%0d want 1 %0h 0",
                         i, b_write_enable, b_data_in, b_address, b_datapath_out);
            end
            tick();
        end
        total++;
        if (b_done_memory_store !== 1'b1 || b_address !== 3'd1) begin
            bad++;
            $display("FAIL b_done: dms=%b addr=%0d want 1 1", b_done_memory_store, b_address);
        end
        tick();
        total++;
        if (b_busy !== 1'b0) begin
            bad++;
            $display("FAIL b_no_queue: busy=%b want 0", b_busy);
        end
    endtask

    initial begin
        resetn          = 1'b1;
        init_memory     = 1'b0;
        load_memory     = 1'b0;
        done_mining     = 1'b0;
        process         = 3'b000;
        starting_memory = 48'hDEAD_BEEF_CAFE;
        mining_hash     = 8'hA5;
        datapath_out    = 48'h1234_5678_9ABC;
        b_init_memory     = 1'b0;
        b_load_memory     = 1'b0;
        b_done_mining     = 1'b0;
        b_process         = 3'b000;
        b_starting_memory = 32'h1111_2222;
        b_mining_hash     = 16'hBEEF;
        b_datapath_out    = 32'hCAFE_F00D;
        #2;
        test_reset();
        test_init();
        test_full_txn();
        test_coincide();
        test_wrap();
        test_reset_mid_write();
        test_stray_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
